rw_bus_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for a single-port register/memory resource that uses a setup-then-access protocol.
- Each requester posts a read or write. The arbiter picks one winner and latches its command.
- It then drives a SETUP cycle and a one-cycle ACCESS strobe (mem_wr_en / mem_rd_en), and returns a done pulse plus read data to the winner.
- Sits between the requester-side logic and the storage block.

---
 rtl/rw_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_rw_bus_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rw_bus_arbiter.sv
// rw_bus_arbiter: two-requester round-robin arbiter that sequences a
// setup-then-access transaction on a single-port storage block.
// Each granted transaction runs IDLE -> SETUP -> ACCESS -> DONE.
module rw_bus_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              req0,
    input  logic              write0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        DONE   = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              cmd_id_q, cmd_id_d;
    logic              cmd_write_q, cmd_write_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              win;

    // Next-state decode and next values of every registered output.
    // mem_addr/mem_wdata double as the latched command address/data.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        cmd_id_d    = cmd_id_q;
        cmd_write_d = cmd_write_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr_en_d = 1'b0;
        mem_rd_en_d = 1'b0;
        win         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win         = (req0 && req1) ? ~last_gnt_q : req1;
                    cmd_id_d    = win;
                    cmd_write_d = win ? write1 : write0;
                    mem_addr_d  = win ? addr1  : addr0;
                    mem_wdata_d = win ? wdata1 : wdata0;
                    last_gnt_d  = win;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                mem_wr_en_d = cmd_write_q;
                mem_rd_en_d = ~cmd_write_q;
                state_d     = ACCESS;
            end
            ACCESS: begin
                if (!cmd_write_q) begin
                    rdata_d = mem_rdata;
                end
                done0_d = ~cmd_id_q;
                done1_d = cmd_id_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, arbitration pointer, command and output registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            cmd_id_q    <= 1'b0;
            cmd_write_q <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            cmd_id_q    <= cmd_id_d;
            cmd_write_q <= cmd_write_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_rd_en_q <= mem_rd_en_d;
        end
    end

    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_rd_en = mem_rd_en_q;

endmodule

// File: tb/tb_rw_bus_arbiter.sv
// Testbench for rw_bus_arbiter: vector table plus directed multi-cycle sequences.
module tb_rw_bus_arbiter;

    logic       clk;
    logic       reset_b;
    logic       req0, write0, req1, write1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       done0, done1, busy, mem_wr_en, mem_rd_en;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic [3:0] mem_addr;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] mem [16];

    rw_bus_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .req0      (req0),
        .write0    (write0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .write1    (write1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .done0     (done0),
        .done1     (done1),
        .rdata     (rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple storage model: combinational read, write on the strobe edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end

    typedef struct {
        logic       r0, w0;
        logic [3:0] a0;
        logic [7:0] d0;
        logic       r1, w1;
        logic [3:0] a1;
        logic [7:0] d1;
        logic [24:0] exp;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [24:0] mk(input logic d0, input logic d1, input logic [7:0] rd,
                                       input logic bz, input logic [3:0] ad, input logic [7:0] wd,
                                       input logic we, input logic re);
        return {d0, d1, rd, bz, ad, wd, we, re};
    endfunction

    function automatic logic [24:0] outs();
        return {done0, done1, rdata, busy, mem_addr, mem_wdata, mem_wr_en, mem_rd_en};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                          input logic r1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
        req0 = r0; write0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; write1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_b = 1'b0;
        set_in(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        step();
        step();
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    int         dn_cyc [4];
    logic       dn_id  [4];
    int         ndone;
    logic [7:0] rd_before;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[7] = 8'h3C;
        mem[6] = 8'h66;
        reset_b = 1'b0;
        set_in(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        #2;
        chk("reset_async_outputs", 32'(outs()), 32'(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0)));
        step();
        chk("reset_outputs", 32'(outs()), 32'(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0)));
        @(negedge clk);
        reset_b = 1'b1;

        // Vector table: single write, single read, contention, write holding rdata.
        vecs[0]  = '{1, 1, 4'h3, 8'hA5, 0, 0, 4'h0, 8'h00, mk(0, 0, 8'h00, 1, 4'h3, 8'hA5, 0, 0)};
        vecs[1]  = '{1, 1, 4'h3, 8'hA5, 0, 0, 4'h0, 8'h00, mk(0, 0, 8'h00, 1, 4'h3, 8'hA5, 1, 0)};
        vecs[2]  = '{1, 1, 4'h3, 8'hA5, 0, 0, 4'h0, 8'h00, mk(1, 0, 8'h00, 1, 4'h3, 8'hA5, 0, 0)};
        vecs[3]  = '{0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, mk(0, 0, 8'h00, 0, 4'h3, 8'hA5, 0, 0)};
        vecs[4]  = '{0, 0, 4'h0, 8'h00, 1, 0, 4'h7, 8'h00, mk(0, 0, 8'h00, 1, 4'h7, 8'h00, 0, 0)};
        vecs[5]  = '{0, 0, 4'h0, 8'h00, 1, 0, 4'h7, 8'h00, mk(0, 0, 8'h00, 1, 4'h7, 8'h00, 0, 1)};
        vecs[6]  = '{0, 0, 4'h0, 8'h00, 1, 0, 4'h7, 8'h00, mk(0, 1, 8'h3C, 1, 4'h7, 8'h00, 0, 0)};
        vecs[7]  = '{0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, mk(0, 0, 8'h3C, 0, 4'h7, 8'h00, 0, 0)};
        vecs[8]  = '{1, 0, 4'h3, 8'hEE, 1, 1, 4'h2, 8'h99, mk(0, 0, 8'h3C, 1, 4'h3, 8'hEE, 0, 0)};
        vecs[9]  = '{1, 0, 4'h3, 8'hEE, 1, 1, 4'h2, 8'h99, mk(0, 0, 8'h3C, 1, 4'h3, 8'hEE, 0, 1)};
        vecs[10] = '{1, 0, 4'h3, 8'hEE, 1, 1, 4'h2, 8'h99, mk(1, 0, 8'hA5, 1, 4'h3, 8'hEE, 0, 0)};
        vecs[11] = '{0, 0, 4'h3, 8'hEE, 1, 1, 4'h2, 8'h99, mk(0, 0, 8'hA5, 0, 4'h3, 8'hEE, 0, 0)};
        vecs[12] = '{0, 0, 4'h0, 8'h00, 1, 1, 4'h2, 8'h99, mk(0, 0, 8'hA5, 1, 4'h2, 8'h99, 0, 0)};
        vecs[13] = '{0, 0, 4'h0, 8'h00, 1, 1, 4'h2, 8'h99, mk(0, 0, 8'hA5, 1, 4'h2, 8'h99, 1, 0)};
        vecs[14] = '{0, 0, 4'h0, 8'h00, 1, 1, 4'h2, 8'h99, mk(0, 1, 8'hA5, 1, 4'h2, 8'h99, 0, 0)};
        vecs[15] = '{0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, mk(0, 0, 8'hA5, 0, 4'h2, 8'h99, 0, 0)};

        for (int i = 0; i < 16; i++) begin
            set_in(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                   vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            step();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        chk("mem3_written", 32'(mem[3]), 32'h0000_00A5);
        chk("mem2_written", 32'(mem[2]), 32'h0000_0099);

        // Simultaneous held requests after reset: grants alternate 0,1,0,1 every 4 cycles.
        do_reset();
        set_in(1, 1, 4'h1, 8'h11, 1, 1, 4'h2, 8'h22);
        ndone = 0;
        for (int c = 0; c < 24 && ndone < 4; c++) begin
            step();
            if (done0 || done1) begin
                dn_cyc[ndone] = c;
                dn_id[ndone]  = done1;
                ndone++;
                if (ndone == 4) set_in(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
            end
        end
        chk("rr_done_count", 32'(ndone), 32'd4);
        for (int k = 0; k < ndone; k++) begin
            chk($sformatf("rr_grant%0d", k), 32'(dn_id[k]), 32'(k % 2));
            if (k > 0) chk($sformatf("rr_spacing%0d", k), 32'(dn_cyc[k] - dn_cyc[k-1]), 32'd4);
        end
        if (ndone > 0) chk("rr_first_latency", 32'(dn_cyc[0]), 32'd2);
        step();
        chk("rr_idle", 32'(busy), 32'd0);

        // Inputs changed while busy have no effect on the transaction in flight.
        set_in(1, 1, 4'h5, 8'h77, 0, 0, 4'h0, 8'h00);
        step();
        chk("chg_setup_addr", 32'({mem_addr, mem_wdata}), 32'({4'h5, 8'h77}));
        set_in(0, 0, 4'h9, 8'h00, 0, 0, 4'h0, 8'h00);
        step();
        chk("chg_access", 32'({mem_wr_en, mem_rd_en, mem_addr, mem_wdata}), 32'({2'b10, 4'h5, 8'h77}));
        step();
        chk("chg_done0", 32'({done0, done1}), 32'({1'b1, 1'b0}));
        step();
        chk("chg_mem5", 32'(mem[5]), 32'h77);
        chk("chg_mem9", 32'(mem[9]), 32'h00);

        // Reset during ACCESS: outputs clear at once, no done, req0 wins afterwards.
        set_in(1, 1, 4'h4, 8'h44, 0, 0, 4'h0, 8'h00);
        step();
        step();
        chk("rst_pre_strobe", 32'(mem_wr_en), 32'd1);
        reset_b = 1'b0;
        #1;
        chk("rst_async_clear", 32'(outs()), 32'(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0)));
        step();
        chk("rst_no_done", 32'(outs()), 32'(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0)));
        chk("rst_no_write", 32'(mem[4]), 32'h00);
        @(negedge clk);
        reset_b = 1'b1;
        set_in(1, 0, 4'h6, 8'h00, 1, 0, 4'h8, 8'h00);
        step();
        chk("rst_req0_wins", 32'(mem_addr), 32'h6);
        step();
        step();
        chk("rst_done0", 32'({done0, done1, rdata}), 32'({1'b1, 1'b0, 8'h66}));
        set_in(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        step();

        // Write then read the same address; rdata untouched by the write.
        rd_before = 8'h66;
        set_in(1, 1, 4'hA, 8'h5A, 0, 0, 4'h0, 8'h00);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("wr_rdata_hold%0d", c), 32'(rdata), 32'(rd_before));
            if (c == 2) begin
                chk("wr_done0", 32'(done0), 32'd1);
                set_in(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
            end
        end
        set_in(0, 0, 4'h0, 8'h00, 1, 0, 4'hA, 8'h00);
        step();
        step();
        chk("rd_strobe", 32'({mem_rd_en, mem_wr_en, mem_addr}), 32'({2'b10, 4'hA}));
        step();
        chk("rd_done1_data", 32'({done1, done0, rdata}), 32'({1'b1, 1'b0, 8'h5A}));
        set_in(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        step();
        chk("rd_idle", 32'({busy, rdata}), 32'({1'b0, 8'h5A}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
